// File: rtl/simmem_pkg.sv
// Shared types for the simmem write path: AW/W/B message layouts, response
// codes and the write-responder FSM encoding.
package simmem_pkg;

   localparam int unsigned IdWidth           = 2;
   localparam int unsigned AddrWidth         = 30;
   localparam int unsigned AxLenWidth        = 8;
   localparam int unsigned AxSizeWidth       = 3;
   localparam int unsigned AxBurstWidth      = 2;
   localparam int unsigned DataWidth         = 4;
   localparam int unsigned StrbWidth         = 4;
   localparam int unsigned WRespCodeWidth    = 2;
   localparam int unsigned WRespBeatsWidth   = 8;
   localparam int unsigned WRespPayloadWidth = WRespCodeWidth + WRespBeatsWidth;
   localparam int unsigned BeatCntWidth      = AxLenWidth + 1;

   typedef struct packed {
      logic [IdWidth-1:0]      id;
      logic [AddrWidth-1:0]    addr;
      logic [AxLenWidth-1:0]   burst_len;
      logic [AxSizeWidth-1:0]  burst_size;
      logic [AxBurstWidth-1:0] burst_type;
   } waddr_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
      logic                 last;
   } wdata_t;

   typedef struct packed {
      logic [IdWidth-1:0]           id;
      logic [WRespPayloadWidth-1:0] payload;
   } wresp_t;

   // Only the fields the responder acts on are queued per pending burst.
   typedef struct packed {
      logic [IdWidth-1:0]    id;
      logic [AxLenWidth-1:0] burst_len;
   } aw_entry_t;

   typedef enum logic [WRespCodeWidth-1:0] {
      WRESP_OKAY   = 2'd0,
      WRESP_EXOKAY = 2'd1,
      WRESP_SLVERR = 2'd2,
      WRESP_DECERR = 2'd3
   } wresp_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } wr_state_e;

   function automatic logic [WRespPayloadWidth-1:0] pack_payload(
      input logic [WRespBeatsWidth-1:0] beats_m1,
      input wresp_code_e                code
   );
      return {beats_m1, code};
   endfunction

endpackage

// File: rtl/simmem_addr_fifo.sv
// Generic synchronous FIFO, power-of-two depth, first-word-fall-through head.
module simmem_addr_fifo #(
   parameter int unsigned Depth = 4,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrWidth:0]   FullCnt  = (PtrWidth+1)'(Depth);

   T                    mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [PtrWidth:0]   count_q;
   logic                do_push;
   logic                do_pop;

   assign full_o  = (count_q == FullCnt);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + (PtrWidth+1)'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - (PtrWidth+1)'(1);
         end
      end
   end

endmodule

// File: rtl/simmem_write_responder.sv
// AXI4 write-channel terminator: queues AW bursts, counts W beats against the
// head burst's length and returns one B response per burst.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no pending burst, no response held; W not accepted
// DATA    | head burst open, W beats accepted and counted
// RESP    | response held on B until accepted; W stalled
module simmem_write_responder
   import simmem_pkg::*;
#(
   parameter int unsigned AddrFifoDepth = 4
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  waddr_t waddr_i,
   input  logic   waddr_in_valid_i,
   output logic   waddr_in_ready_o,
   input  wdata_t wdata_i,
   input  logic   wdata_in_valid_i,
   output logic   wdata_in_ready_o,
   output wresp_t wresp_o,
   output logic   wresp_out_valid_o,
   input  logic   wresp_out_ready_i
);

   wr_state_e               state_q;
   wr_state_e               state_d;
   aw_entry_t               aw_entry;
   aw_entry_t               head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_pop;
   logic                    w_hs;
   logic                    b_hs;
   logic                    burst_done;
   logic                    last_on_time;
   logic [BeatCntWidth-1:0] beat_cnt_q;
   logic [BeatCntWidth-1:0] beat_next;
   logic [BeatCntWidth-1:0] expected;
   wresp_t                  resp_q;
   logic                    unused_fields;

   assign aw_entry = '{id: waddr_i.id, burst_len: waddr_i.burst_len};

   simmem_addr_fifo #(
      .Depth (AddrFifoDepth),
      .T     (aw_entry_t)
   ) u_addr_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (waddr_in_valid_i),
      .data_i  (aw_entry),
      .pop_i   (fifo_pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign waddr_in_ready_o = ~fifo_full;

   assign w_hs       = wdata_in_valid_i & wdata_in_ready_o;
   assign b_hs       = wresp_out_valid_o & wresp_out_ready_i;
   assign beat_next  = beat_cnt_q + BeatCntWidth'(1);
   assign expected   = {1'b0, head.burst_len} + BeatCntWidth'(1);
   // A missing last still closes the burst once the advertised length is reached.
   assign burst_done   = w_hs & (wdata_i.last | (beat_next == expected));
   assign last_on_time = wdata_i.last & (beat_next == expected);
   assign fifo_pop     = burst_done;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_DATA;
         ST_DATA: if (burst_done) state_d = ST_RESP;
         ST_RESP: if (b_hs)       state_d = fifo_empty ? ST_IDLE : ST_DATA;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wdata_in_ready_o  = 1'b0;
      wresp_out_valid_o = 1'b0;
      unique case (state_q)
         ST_DATA: wdata_in_ready_o  = 1'b1;
         ST_RESP: wresp_out_valid_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         beat_cnt_q <= '0;
         resp_q     <= '0;
      end else begin
         if (burst_done) begin
            beat_cnt_q     <= '0;
            resp_q.id      <= head.id;
            resp_q.payload <= pack_payload(beat_cnt_q[WRespBeatsWidth-1:0],
                                           last_on_time ? WRESP_OKAY : WRESP_SLVERR);
         end else if (w_hs) begin
            beat_cnt_q <= beat_next;
         end
      end
   end

   assign wresp_o = resp_q;

   assign unused_fields = ^{waddr_i.addr, waddr_i.burst_size, waddr_i.burst_type,
                            wdata_i.data, wdata_i.strb};

endmodule
